bmem_arbiter: RTL

- Sits between the core's instruction cache and data cache and the single banked memory port.
- Takes 256-bit cacheline reads and writes from the two caches and turns them into the banked memory's 4-beat, 64-bit burst protocol.
- Reassembles returned read beats into a full line and returns a one-cycle response to the requester that was granted.
- One memory transaction is outstanding at a time; arbitration between the two caches is round-robin.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/bmem_line_assembler.sv | 69 ++++++
 rtl/bmem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types and constants for the core's memory-side blocks.
//   - Cacheline / banked-memory geometry constants.
//   - bmem_arb_state_t : state encoding of the banked-memory arbiter.
//   - requester_t      : identity of the cache that owns a transaction.
package rv32i_types;

  localparam int BMEM_ADDR_W    = 32;
  localparam int CACHELINE_W    = 256;
  localparam int BMEM_BEAT_W    = 64;
  localparam int BMEM_BURST_LEN = CACHELINE_W / BMEM_BEAT_W;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP
  } bmem_arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } requester_t;

endpackage

// File: rtl/bmem_line_assembler.sv
// Line buffer shared by the read-collect and write-serialize paths.
// Holds one cacheline plus the beat counter that indexes it.
// Ports:
//   clk, rst     : clock, synchronous active-low reset (clears the counter)
//   i_load       : load i_line and restart the counter at beat 0
//   i_line       : full line to load (writeback data)
//   i_capture    : insert i_beat at the current beat slot and advance
//   i_beat       : returned read beat
//   i_advance    : advance the counter without touching the line (write beat accepted)
//   o_beat       : line slice selected by the counter (write beat to send)
//   o_line_next  : line with i_beat inserted at the current slot
//   o_last       : counter is on the final beat of the burst
module bmem_line_assembler
  import rv32i_types::*;
#(
  parameter int LINE_W    = CACHELINE_W,
  parameter int BEAT_W    = BMEM_BEAT_W,
  parameter int BURST_LEN = BMEM_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_line,
  input  logic              i_capture,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic              i_advance,
  output logic [BEAT_W-1:0] o_beat,
  output logic [LINE_W-1:0] o_line_next,
  output logic              o_last
);

  localparam int CNT_W = $clog2(BURST_LEN);

  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_capture || i_advance) begin
      r_cnt <= r_cnt + 1'b1;  // wraps back to 0 after the last beat
    end
  end

  // NOTE: the line buffer is pure datapath and is deliberately left out of
  // reset; it is always fully loaded or fully overwritten before it is read.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_line <= i_line;
    end else if (i_capture) begin
      r_line <= o_line_next;
    end
  end

  // NOTE: combinational outputs get a full default before the indexed
  // overwrite, so no path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    o_line_next = r_line;
    o_line_next[int'(r_cnt) * BEAT_W +: BEAT_W] = i_beat;
  end

  assign o_beat = r_line[int'(r_cnt) * BEAT_W +: BEAT_W];
  assign o_last = (r_cnt == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/bmem_arbiter.sv
// Arbiter between the instruction and data caches and the single banked
// memory port. Converts cacheline reads/writes into 4-beat bursts, one
// transaction outstanding, round-robin between the two caches.
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   icache_addr/read                : icache line read request (held until resp)
//   icache_rdata/resp               : assembled line + one-cycle completion
//   dcache_addr/read/write/wdata    : dcache read or writeback request
//   dcache_rdata/resp               : assembled line + one-cycle completion
//   bmem_addr/read/write/wdata      : burst command / write beat to memory
//   bmem_ready                      : memory accepts command or beat
//   bmem_raddr/rdata/rvalid         : tagged returned read beat
module bmem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W    = BMEM_ADDR_W,
  parameter int LINE_W    = CACHELINE_W,
  parameter int BEAT_W    = BMEM_BEAT_W,
  parameter int BURST_LEN = BMEM_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_read,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_W / 8 - 1);

  bmem_arb_state_t   r_state, w_next_state;
  requester_t        r_req, r_last_grant, w_grant;
  logic [ADDR_W-1:0] r_addr, w_grant_addr;
  logic [LINE_W-1:0] r_icache_rdata, r_dcache_rdata;
  logic              w_dreq, w_grant_valid, w_grant_write;
  logic              w_load, w_capture, w_advance, w_last;
  logic [BEAT_W-1:0] w_beat;
  logic [LINE_W-1:0] w_line_next;

  // Round-robin: on a tie the cache that did not win last time is granted.
  always_comb begin
    w_dreq        = dcache_read || dcache_write;
    w_grant_valid = icache_read || w_dreq;
    w_grant       = ICACHE;
    if (icache_read && w_dreq) begin
      w_grant = (r_last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (w_dreq) begin
      w_grant = DCACHE;
    end
    // A dcache write wins over a simultaneous (illegal) dcache read.
    w_grant_write = (w_grant == DCACHE) && dcache_write;
    w_grant_addr  = (w_grant == DCACHE) ? dcache_addr : icache_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    icache_resp  = 1'b0;
    dcache_resp  = 1'b0;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          // Loading wdata on a read grant is harmless: all four beats overwrite it.
          w_load       = 1'b1;
          w_next_state = w_grant_write ? WR : RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        if (bmem_ready) w_next_state = RD_WAIT;
      end
      RD_WAIT: begin
        // Beats tagged for some other line are not ours and are dropped.
        if (bmem_rvalid && (bmem_raddr == r_addr)) begin
          w_capture = 1'b1;
          if (w_last) w_next_state = RESP;
        end
      end
      WR: begin
        bmem_write = 1'b1;
        if (bmem_ready) begin
          w_advance = 1'b1;
          if (w_last) w_next_state = RESP;
        end
      end
      RESP: begin
        icache_resp  = (r_req == ICACHE);
        dcache_resp  = (r_req == DCACHE);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr         <= '0;
      r_req          <= ICACHE;
      r_last_grant   <= ICACHE;
      r_icache_rdata <= '0;
      r_dcache_rdata <= '0;
    end else begin
      if (w_load) begin
        r_addr       <= w_grant_addr & ~OFFSET_MASK;
        r_req        <= w_grant;
        r_last_grant <= w_grant;
      end
      // Only the owner's line register changes; the other keeps its last line.
      if (w_capture && w_last) begin
        if (r_req == ICACHE) r_icache_rdata <= w_line_next;
        else                 r_dcache_rdata <= w_line_next;
      end
    end
  end

  bmem_line_assembler #(
    .LINE_W   (LINE_W),
    .BEAT_W   (BEAT_W),
    .BURST_LEN(BURST_LEN)
  ) u_line (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_line     (dcache_wdata),
    .i_capture  (w_capture),
    .i_beat     (bmem_rdata),
    .i_advance  (w_advance),
    .o_beat     (w_beat),
    .o_line_next(w_line_next),
    .o_last     (w_last)
  );

  assign bmem_addr    = r_addr;
  assign bmem_wdata   = (r_state == WR) ? w_beat : '0;
  assign icache_rdata = r_icache_rdata;
  assign dcache_rdata = r_dcache_rdata;

  a_no_dcache_rd_wr: assert property (@(posedge clk) disable iff (!rst)
    !(dcache_read && dcache_write));

endmodule
